// File: rtl/b_bop_arb_pkg.sv
// Shared definitions for the b_bop arbiter: buffer states, port ids, widths
// and the per-bit truth-table lookup.
package b_bop_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  localparam int   XLEN  = 32;
  localparam int   LUT_W = 8;

  // One result bit: the truth table indexed by {rd,rs1,rs2}.
  function automatic logic bop_bit(input logic [LUT_W-1:0] lut,
                                   input logic rd, input logic rs1, input logic rs2);
    return lut[{rd, rs1, rs2}];
  endfunction

endpackage

// File: rtl/b_bop_arb_bop.sv
// Combinational 3-input bitwise LUT: result[i] = lut[{rd[i],rs1[i],rs2[i]}].
module b_bop_arb_bop
  import b_bop_arb_pkg::*;
(
  input  logic [XLEN-1:0]  rd,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [LUT_W-1:0] lut,
  output logic [XLEN-1:0]  result
);

  always_comb begin
    result = '0;
    for (int i = 0; i < XLEN; i++) begin
      result[i] = bop_bit(lut, rd[i], rs1[i], rs2[i]);
    end
  end

endmodule

// File: rtl/b_bop_arb.sv
// Two-port arbiter sharing one b_bop datapath, with a single-entry tagged
// response buffer released under its own valid/ready handshake.
module b_bop_arb
  import b_bop_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_rd,
  input  logic [XLEN-1:0]  req0_rs1,
  input  logic [XLEN-1:0]  req0_rs2,
  input  logic [LUT_W-1:0] req0_lut,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_rd,
  input  logic [XLEN-1:0]  req1_rs1,
  input  logic [XLEN-1:0]  req1_rs2,
  input  logic [LUT_W-1:0] req1_lut,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic             rsp_id
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_prio;
  logic [XLEN-1:0]  r_result_p1;
  logic             r_id_p1;

  logic             w_accept;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_gnt_id;
  logic             w_fire;
  logic [XLEN-1:0]  w_rd;
  logic [XLEN-1:0]  w_rs1;
  logic [XLEN-1:0]  w_rs2;
  logic [LUT_W-1:0] w_lut;
  logic [XLEN-1:0]  w_bop_result;

  // Port 1 wins only if alone, or under round-robin when the pointer favours it.
  assign w_gnt1   = req1_valid & (~req0_valid | (ROUND_ROBIN & (r_prio == PORT1)));
  assign w_gnt0   = req0_valid & ~w_gnt1;
  assign w_gnt_id = w_gnt1 ? PORT1 : PORT0;

  assign req0_ready = w_accept & w_gnt0 & ~reset;
  assign req1_ready = w_accept & w_gnt1 & ~reset;
  assign w_fire     = req0_ready | req1_ready;

  assign w_rd  = w_gnt1 ? req1_rd  : req0_rd;
  assign w_rs1 = w_gnt1 ? req1_rs1 : req0_rs1;
  assign w_rs2 = w_gnt1 ? req1_rs2 : req0_rs2;
  assign w_lut = w_gnt1 ? req1_lut : req0_lut;

  b_bop_arb_bop u_bop (
    .rd     (w_rd),
    .rs1    (w_rs1),
    .rs2    (w_rs2),
    .lut    (w_lut),
    .result (w_bop_result)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_prio  <= PORT0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) r_prio <= ~w_gnt_id;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_fire)                                  w_state_nxt = ST_FULL;
    else if ((r_state == ST_FULL) && rsp_ready)  w_state_nxt = ST_EMPTY;
  end

  always_comb begin
    rsp_valid = (r_state == ST_FULL);
    w_accept  = (r_state == ST_EMPTY) | rsp_ready;
  end

  // Stage p1: captured result and tag; they hold when the entry drains.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result_p1 <= '0;
      r_id_p1     <= PORT0;
    end else if (w_fire) begin
      r_result_p1 <= w_bop_result;
      r_id_p1     <= w_gnt_id;
    end
  end

  assign rsp_result = r_result_p1;
  assign rsp_id     = r_id_p1;

endmodule

// File: doc/b_bop_arb.md
Name: b_bop_arb

Overview:
Two-port arbiter and issue controller that shares one b_bop datapath instance (3-input bitwise LUT: result[i] = lut[{rd[i],rs1[i],rs2[i]}]) between two requesters, for example the scalar issue path and a crypto coprocessor sequencer.
- Each requester presents operands under a valid/ready handshake.
- The block arbitrates between the two ports and drives the shared b_bop.
- The result is registered into a single-entry response buffer, tagged with the winning port id.
- The response is released under its own valid/ready handshake.

Parameters:
ROUND_ROBIN, 1, 1 = round-robin arbitration between ports; 0 = fixed priority with port 0 always winning.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
req0_valid  input  1  port 0 request valid.
req0_ready  output  1  port 0 request accepted this cycle.
req0_rd  input  32  port 0 rd operand.
req0_rs1  input  32  port 0 rs1 operand.
req0_rs2  input  32  port 0 rs2 operand.
req0_lut  input  8  port 0 truth table.
req1_valid  input  1  port 1 request valid.
req1_ready  output  1  port 1 request accepted this cycle.
req1_rd  input  32  port 1 rd operand.
req1_rs1  input  32  port 1 rs1 operand.
req1_rs2  input  32  port 1 rs2 operand.
req1_lut  input  8  port 1 truth table.
rsp_valid  output  1  response buffer holds a result.
rsp_ready  input  1  consumer accepts the response.
rsp_result  output  32  registered b_bop result.
rsp_id  output  1  index of the port that issued the result.

Behaviour:
- Reset (synchronous, active-high):
  - rsp_valid=0, rsp_result=0, rsp_id=0.
  - Priority pointer prio=0, so port 0 is favoured first.
  - A pending response is discarded. No request is accepted during the reset cycle (reqN_ready=0).
- Buffer state machine:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - accept = (state==EMPTY) | rsp_ready. This gives full throughput: a new request is accepted in the same cycle the old response is consumed.
- Grant:
  - If only one port is valid, that port is granted.
  - If both are valid: with ROUND_ROBIN=1 the port equal to prio is granted; with ROUND_ROBIN=0 port 0 is granted.
  - reqN_ready = accept & grantN & ~reset. At most one ready is high per cycle.
  - A ready output may be high only while its own valid is high.
- Datapath mux and issue:
  - The granted port's {rd,rs1,rs2,lut} is muxed into the single b_bop instance.
  - On handshake (reqN_valid & reqN_ready) at edge T: rsp_result<=b_bop.result, rsp_id<=N, rsp_valid<=1.
  - rsp_valid is visible from cycle T+1, so latency is exactly 1 cycle.
- Pointer update:
  - On any grant, prio <= ~granted_id, so a lone requester does not hold priority.
  - prio is unused when ROUND_ROBIN=0.
  - Fairness: with both ports continuously valid, grants alternate 0,1,0,1. A waiting port waits at most one other grant while the consumer is ready.
- Response transitions:
  - FULL & rsp_ready & no new handshake -> EMPTY (rsp_valid<=0; rsp_result and rsp_id hold their last values).
  - FULL & ~rsp_ready: no request is accepted, and rsp_result and rsp_id stay stable.
  - Simultaneous consume and accept: the state stays FULL and the data is replaced by the new result.
- Requester rules: once reqN_valid is raised it stays high, with stable operands, until reqN_ready. Violations are not checked.
- No combinational path from rsp_ready to rsp_* outputs. A combinational path from rsp_ready to reqN_ready is permitted.

Decomposition:
- Shared header b_bop_arb_defs.vh:
  - localparams ST_EMPTY=1'b0, ST_FULL=1'b1.
  - PORT0=1'b0, PORT1=1'b1.
  - XLEN=32, LUT_W=8.
- One sub-module: instance of the existing combinational b_bop (ports rd, rs1, rs2, lut, result), fed from the grant mux.
- A formal bench b_bop_arb_ftb reuses fml_b_bop_checker against the captured operands to assert rsp_result.

Test Plan:
- Single request, xor3: port0 rd=0xFFFF0000, rs1=0xFF00FF00, rs2=0xF0F0F0F0, lut=0x96, rsp_ready=1 -> req0_ready same cycle; next cycle rsp_valid=1, rsp_result=0xF00F0FF0, rsp_id=0.
- Majority on port 1: same operands on port1, lut=0xE8 -> rsp_result=0xFFF0F000, rsp_id=1.
- Contention, ROUND_ROBIN=1: both ports valid for 4 cycles, rsp_ready=1 -> grants in order 0,1,0,1; rsp_id sequence 0,1,0,1 delayed by 1 cycle.
- Backpressure: rsp_ready=0 for 3 cycles with the buffer FULL -> both readys 0, rsp_result stable. On the cycle rsp_ready=1 -> a new request is accepted in that same cycle and rsp_valid stays 1.
- Fixed priority, ROUND_ROBIN=0: both ports valid continuously -> port 0 granted every cycle, req1_ready never 1.
- Reset mid-operation: assert reset while rsp_valid=1 and both ports valid -> next cycle rsp_valid=0, rsp_result=0, rsp_id=0, no ready asserted. First post-reset contention grants port 0.
